// File: rtl/mfcc_regc_pkg.sv
// Shared definitions for the register-C source mux / accumulator:
// op codes, FSM state encoding and saturation constant helpers.
package mfcc_regc_pkg;

   // Operation applied to register C
   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_ACC   = 2'b01,
      OP_SUB   = 2'b10,
      OP_CLEAR = 2'b11
   } regc_op_e;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      OUT  = 2'b10
   } regc_state_e;

   // Widest data path the saturation helpers support
   localparam int unsigned SAT_MAX_W = 64;

   // Largest positive signed value of a w-bit word, in the low w bits
   function automatic logic [SAT_MAX_W-1:0] sat_pos(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Most negative signed value of a w-bit word, in the low w bits
   function automatic logic [SAT_MAX_W-1:0] sat_neg(input int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/regc_alu.sv
// Combinational register-C update: load, accumulate, subtract, clear.
// ACC/SUB use a one-bit-wider signed intermediate for overflow detection.
// Build option REGC_SAT_EN: saturate on overflow instead of wrapping.
module regc_alu
   import mfcc_regc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  regc_op_e          op,
   input  logic [WIDTH-1:0]  c_val,
   input  logic [WIDTH-1:0]  operand,
   output logic [WIDTH-1:0]  result,
   output logic              ovf
);

   logic [WIDTH:0] ext_c;
   logic [WIDTH:0] ext_o;
   logic [WIDTH:0] sum;
   logic           ovf_raw;

`ifdef REGC_SAT_EN
   localparam logic [SAT_MAX_W-1:0] SAT_POS_L = sat_pos(WIDTH);
   localparam logic [SAT_MAX_W-1:0] SAT_NEG_L = sat_neg(WIDTH);
   localparam logic [WIDTH-1:0]     SAT_POS   = SAT_POS_L[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAT_NEG   = SAT_NEG_L[WIDTH-1:0];
`endif

   assign ext_c   = {c_val[WIDTH-1], c_val};
   assign ext_o   = {operand[WIDTH-1], operand};
   assign sum     = (op == OP_SUB) ? (ext_c - ext_o) : (ext_c + ext_o);
   // Sign of the wide result disagrees with the narrow sign bit on overflow
   assign ovf_raw = sum[WIDTH] ^ sum[WIDTH-1];

   // Select the new register-C value and qualify overflow with the op
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      result = '0;
      ovf    = 1'b0;
      unique case (op)
         OP_LOAD:  result = operand;
         OP_CLEAR: result = '0;
         OP_ACC, OP_SUB: begin
            ovf = ovf_raw;
`ifdef REGC_SAT_EN
            if (ovf_raw) result = sum[WIDTH] ? SAT_NEG : SAT_POS;
            else         result = sum[WIDTH-1:0];
`else
            result = sum[WIDTH-1:0];
`endif
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/regc_mux_acc.sv
// Register-C source mux and accumulator. Selects one of NSRC signed
// sources, latches it with the op, updates C one cycle later and holds
// the result on an output handshake. Out-of-range selects map to the
// last channel. Build option REGC_SAT_EN enables saturating ACC/SUB.
module regc_mux_acc
   import mfcc_regc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NSRC  = 4,
   parameter int SELW  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       src_valid,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SELW-1:0]       in_sel,
   input  logic [1:0]            in_op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  err,
   output logic                  ovf
);

   localparam logic [SELW-1:0] LAST_SEL = SELW'(NSRC - 1);
   localparam logic [SELW:0]   NSRC_W   = (SELW + 1)'(NSRC);

   regc_state_e       state;
   regc_op_e          op_q;
   logic [WIDTH-1:0]  c_reg;
   logic [WIDTH-1:0]  opnd_q;
   logic              vld_q;

   logic [SELW-1:0]   sel_idx;
   logic [WIDTH-1:0]  sel_data;
   logic              sel_vld;
   logic [WIDTH-1:0]  alu_result;
   logic              alu_ovf;

   assign sel_idx  = ({1'b0, in_sel} >= NSRC_W) ? LAST_SEL : in_sel;
   assign out_data = c_reg;

   // Source mux: pick the selected channel's data and valid qualifier
   always_comb begin
      sel_data = '0;
      sel_vld  = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (sel_idx == SELW'(i)) begin
            sel_data = src_data[i*WIDTH +: WIDTH];
            sel_vld  = src_valid[i];
         end
      end
   end

   regc_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op      (op_q),
      .c_val   (c_reg),
      .operand (opnd_q),
      .result  (alu_result),
      .ovf     (alu_ovf)
   );

   // Control FSM with registered handshake outputs, register C and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_LOAD;
         c_reg     <= '0;
         opnd_q    <= '0;
         vld_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         err       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  opnd_q   <= sel_data;
                  op_q     <= regc_op_e'(in_op);
                  vld_q    <= sel_vld;
                  in_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               c_reg <= alu_result;
               if (op_q == OP_CLEAR) begin
                  err <= 1'b0;
                  ovf <= 1'b0;
               end else begin
                  if (!vld_q)  err <= 1'b1;
                  if (alu_ovf) ovf <= 1'b1;
               end
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regc_mux_acc.sv
// Directed self-checking bench for regc_mux_acc. Main instance uses the
// default 4-source build; a second instance uses NSRC=3 to exercise the
// out-of-range select. Expected values follow the REGC_SAT_EN setting.
module tb_regc_mux_acc;

   logic        clk;
   logic        rst_n;

   logic [63:0] src_data;
   logic [3:0]  src_valid;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        err;
   logic        ovf;

   logic [47:0] src_data3;
   logic [2:0]  src_valid3;
   logic        in_valid3;
   logic        in_ready3;
   logic [1:0]  in_sel3;
   logic [1:0]  in_op3;
   logic        out_valid3;
   logic        out_ready3;
   logic [15:0] out_data3;
   logic        err3;
   logic        ovf3;

   int n_checks = 0;
   int n_fail   = 0;

   regc_mux_acc #(.WIDTH(16), .NSRC(4), .SELW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_data  (src_data),
      .src_valid (src_valid),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .ovf       (ovf)
   );

   regc_mux_acc #(.WIDTH(16), .NSRC(3), .SELW(2)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_data  (src_data3),
      .src_valid (src_valid3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .in_sel    (in_sel3),
      .in_op     (in_op3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .out_data  (out_data3),
      .err       (err3),
      .ovf       (ovf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op with out_ready=1 and check the full handshake timing.
   // Called #1 after a rising edge with in_ready expected high.
   task automatic do_op(input string tag, input logic [1:0] sel, input logic [1:0] op,
                        input logic [15:0] data, input logic vld,
                        input logic [15:0] exp_data, input logic exp_err, input logic exp_ovf);
      src_data         = {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
      src_data[sel*16 +: 16] = data;
      src_valid        = 4'hF;
      src_valid[sel]   = vld;
      in_sel           = sel;
      in_op            = op;
      out_ready        = 1'b1;
      in_valid         = 1'b1;
      check({tag, "/rdy_pre"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;                       // accept edge k
      in_valid = 1'b0;
      src_data = '0;
      check({tag, "/rdy_busy"}, 32'(in_ready), 32'd0);
      check({tag, "/ov_early"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;                       // edge k+1: result presented
      check({tag, "/out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/data"}, 32'(out_data), 32'(exp_data));
      check({tag, "/err"}, 32'(err), 32'(exp_err));
      check({tag, "/ovf"}, 32'(ovf), 32'(exp_ovf));
      check({tag, "/rdy_out"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;                       // edge k+2: back to idle
      check({tag, "/ov_done"}, 32'(out_valid), 32'd0);
      check({tag, "/rdy_done"}, 32'(in_ready), 32'd1);
   endtask

   logic [15:0] exp_acc_ovf;
   logic [15:0] exp_sub_ovf;

   initial begin
`ifdef REGC_SAT_EN
      exp_acc_ovf = 16'h7FFF;
      exp_sub_ovf = 16'h8000;
`else
      exp_acc_ovf = 16'h8010;
      exp_sub_ovf = 16'h7FFF;
`endif
      rst_n      = 1'b0;
      src_data   = '0;
      src_valid  = '0;
      in_valid   = 1'b0;
      in_sel     = '0;
      in_op      = '0;
      out_ready  = 1'b1;
      src_data3  = '0;
      src_valid3 = '0;
      in_valid3  = 1'b0;
      in_sel3    = '0;
      in_op3     = '0;
      out_ready3 = 1'b1;

      // Reset state
      #12;
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/in_ready", 32'(in_ready), 32'd1);
      check("rst/out_data", 32'(out_data), 32'd0);
      check("rst/err", 32'(err), 32'd0);
      check("rst/ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: basic LOAD from channel 1
      do_op("t1_load", 2'd1, 2'b00, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0);
      do_op("t1_acc_ld", 2'd0, 2'b00, 16'h0100, 1'b1, 16'h0100, 1'b0, 1'b0);
      do_op("t1_acc", 2'd3, 2'b01, 16'h0023, 1'b1, 16'h0123, 1'b0, 1'b0);

      // 2: positive overflow on ACC, then CLEAR
      do_op("t2_load", 2'd2, 2'b00, 16'h7FF0, 1'b1, 16'h7FF0, 1'b0, 1'b0);
      do_op("t2_acc", 2'd0, 2'b01, 16'h0020, 1'b1, exp_acc_ovf, 1'b0, 1'b1);
      do_op("t2_clear", 2'd1, 2'b11, 16'h5A5A, 1'b1, 16'h0000, 1'b0, 1'b0);

      // 3: SUB below zero, then negative overflow on SUB
      do_op("t3_load", 2'd0, 2'b00, 16'h0005, 1'b1, 16'h0005, 1'b0, 1'b0);
      do_op("t3_sub", 2'd1, 2'b10, 16'h0008, 1'b1, 16'hFFFD, 1'b0, 1'b0);
      do_op("t3_ldmin", 2'd3, 2'b00, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0);
      do_op("t3_subovf", 2'd2, 2'b10, 16'h0001, 1'b1, exp_sub_ovf, 1'b0, 1'b1);
      do_op("t3_clear", 2'd0, 2'b11, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);

      // 4: NSRC=3 instance, in_sel=3 defaults to channel 2
      src_data3  = {16'h00AA, 16'h0022, 16'h0011};
      src_valid3 = 3'b111;
      in_sel3    = 2'd3;
      in_op3     = 2'b00;
      in_valid3  = 1'b1;
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      @(posedge clk); #1;
      check("t4_ovalid", 32'(out_valid3), 32'd1);
      check("t4_default_sel", 32'(out_data3), 32'h00AA);
      check("t4_err", 32'(err3), 32'd0);
      @(posedge clk); #1;
      check("t4_rdy", 32'(in_ready3), 32'd1);

      // 5: invalid source sets sticky err; only CLEAR removes it
      do_op("t5_bad", 2'd2, 2'b00, 16'h5555, 1'b0, 16'h5555, 1'b1, 1'b0);
      do_op("t5_good", 2'd1, 2'b00, 16'h0101, 1'b1, 16'h0101, 1'b1, 1'b0);
      do_op("t5_clear", 2'd3, 2'b11, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);

      // 6: backpressure with in_valid held, then reset mid-OUT
      src_data  = {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h4321};
      src_valid = 4'hF;
      in_sel    = 2'd0;
      in_op     = 2'b00;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_op    = 2'b01;
      src_data = {16'h1111, 16'h1111, 16'h1111, 16'h1111};
      @(posedge clk); #1;
      check("t6_enter_out", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("t6_hold_valid%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("t6_hold_data%0d", i), 32'(out_data), 32'h4321);
         check($sformatf("t6_hold_rdy%0d", i), 32'(in_ready), 32'd0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_data", 32'(out_data), 32'd0);
      check("t6_rst_rdy", 32'(in_ready), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_post_idle", 32'(out_valid), 32'd0);
      do_op("t6_after", 2'd1, 2'b01, 16'h0042, 1'b1, 16'h0042, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
